// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised TLP FIFO: transaction-layer state
// encodings and the pointer-width helper.
package fifo_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } fifo_state_e;

    // Smallest n with 2**n >= value; the fixed loop bound keeps it elaboration-friendly.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM for the FIFO: one write port and one registered read
// port with read-before-write on a same-address collision.
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8,
    localparam int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_srst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage write port; the array itself is intentionally never cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; sampling the pre-edge array value yields old data on collision.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_srst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/param_fifo.sv
// Parametrised TLP FIFO with occupancy/threshold flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            state,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   umbral_superior,
    input  logic [ADDR_WIDTH:0]   umbral_inferior,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [CNT_W-1:0]      r_count, w_count_nxt;
    logic [CNT_W-1:0]      r_thr_hi, r_thr_lo, w_thr_hi_nxt, w_thr_lo_nxt;
    logic                  r_full, r_empty, r_almost_full, r_almost_empty;
    logic                  r_overflow, r_underflow, r_valid;
    logic                  w_srst, w_op_en, w_push_ok, w_pop_ok, w_ram_re;
    logic [ADDR_WIDTH-1:0] w_ram_raddr;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_srst    = (state == ST_RESET);
    assign w_op_en   = (state == ST_IDLE) || (state == ST_ACTIVE);
    assign w_pop_ok  = w_op_en & pop & ~r_empty;
    assign w_push_ok = w_op_en & push & (~r_full | w_pop_ok);

    // Next pointers, occupancy and latched thresholds; RESET state folds in as a clear.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_thr_hi_nxt = r_thr_hi;
        w_thr_lo_nxt = r_thr_lo;
        if (w_srst) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
            w_thr_hi_nxt = '0;
            w_thr_lo_nxt = '0;
        end else begin
            if (w_push_ok) begin
                w_wr_ptr_nxt = r_wr_ptr + ADDR_WIDTH'(1);
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
            if (w_pop_ok) begin
                w_rd_ptr_nxt = r_rd_ptr + ADDR_WIDTH'(1);
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
            if (state == ST_INIT) begin
                w_thr_hi_nxt = (umbral_superior > DEPTH_C) ? DEPTH_C : umbral_superior;
                w_thr_lo_nxt = (umbral_inferior > DEPTH_C) ? DEPTH_C : umbral_inferior;
            end else begin
                w_thr_hi_nxt = r_thr_hi;
                w_thr_lo_nxt = r_thr_lo;
            end
        end
    end

    // Core state; flags come from next-state values so they agree with count every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_thr_hi       <= '0;
            r_thr_lo       <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_valid        <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_thr_hi       <= w_thr_hi_nxt;
            r_thr_lo       <= w_thr_lo_nxt;
            r_full         <= (w_count_nxt == DEPTH_C);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= ~w_srst & (w_count_nxt >= w_thr_hi_nxt);
            r_almost_empty <= ~w_srst & (w_count_nxt <= w_thr_lo_nxt);
            r_overflow     <= ~w_srst & (r_overflow | (w_op_en & push & ~w_push_ok));
            r_underflow    <= ~w_srst & (r_underflow | (w_op_en & pop & r_empty));
`ifdef FIFO_FWFT_EN
            r_valid        <= (w_count_nxt != '0);
`else
            r_valid        <= w_pop_ok;
`endif
        end
    end

`ifdef FIFO_FWFT_EN
    logic                  r_byp;
    logic [DATA_WIDTH-1:0] r_byp_data;

    assign w_ram_re    = 1'b1;
    assign w_ram_raddr = w_rd_ptr_nxt;

    // A word landing in the slot that becomes head this edge is not yet visible through the RAM read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byp      <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp      <= w_push_ok & (r_wr_ptr == w_rd_ptr_nxt);
            r_byp_data <= data_in;
        end
    end

    assign data_out = r_byp ? r_byp_data : w_ram_rdata;
`else
    assign w_ram_re    = w_pop_ok;
    assign w_ram_raddr = r_rd_ptr;
    assign data_out    = w_ram_rdata;
`endif

    fifo_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_rst   (reset),
        .i_srst  (w_srst),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    assign valid_out    = r_valid;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_param_fifo;

    localparam int DW    = 10;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam logic [3:0] S_RESET  = 4'b0001;
    localparam logic [3:0] S_INIT   = 4'b0010;
    localparam logic [3:0] S_IDLE   = 4'b0100;
    localparam logic [3:0] S_ACTIVE = 4'b1000;

    logic          clk, reset, push, pop, valid_out;
    logic [3:0]    state;
    logic [DW-1:0] data_in, data_out;
    logic [AW:0]   umbral_superior, umbral_inferior, count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model
    logic [DW-1:0] q[$];
    int            m_thr_hi, m_thr_lo;
    bit            m_ovf, m_udf, m_valid, m_rst;
    logic [DW-1:0] m_dout;

    param_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .state(state), .push(push), .pop(pop),
        .data_in(data_in), .umbral_superior(umbral_superior), .umbral_inferior(umbral_inferior),
        .data_out(data_out), .valid_out(valid_out), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_thr_hi = 0;
        m_thr_lo = 0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_valid  = 1'b0;
        m_rst    = 1'b1;
        m_dout   = '0;
    endtask

    task automatic model_step(input logic [3:0] st, input logic ps, input logic pp, input logic [DW-1:0] din);
        bit pop_ok, push_ok;
        if (st == S_RESET) begin
            model_reset();
        end else begin
            m_rst = 1'b0;
            if (st == S_INIT) begin
                m_thr_hi = (int'(umbral_superior) > DEPTH) ? DEPTH : int'(umbral_superior);
                m_thr_lo = (int'(umbral_inferior) > DEPTH) ? DEPTH : int'(umbral_inferior);
            end
            if (st == S_IDLE || st == S_ACTIVE) begin
                pop_ok  = pp && (q.size() > 0);
                push_ok = ps && ((q.size() < DEPTH) || pop_ok);
                if (ps && !push_ok) m_ovf = 1'b1;
                if (pp && q.size() == 0) m_udf = 1'b1;
                if (pop_ok) m_dout = q.pop_front();
                if (push_ok) q.push_back(din);
                m_valid = pop_ok;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // one clock: apply inputs, step model at the edge, settle 1 time unit past it
    task automatic cyc(input logic [3:0] st, input logic ps, input logic pp, input logic [DW-1:0] din);
        state   = st;
        push    = ps;
        pop     = pp;
        data_in = din;
        @(posedge clk);
        model_step(st, ps, pp, din);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; state = S_RESET; push = 1'b0; pop = 1'b0; data_in = '0;
        umbral_superior = '0; umbral_inferior = '0;
        #1 reset = 1'b1;
        #2;
        model_reset();
        n_checks++;
        if ({count, full, empty, valid_out, overflow, underflow, almost_full, almost_empty} !== 11'b0000_0100000)
            $display("FAIL reset_outputs: got %b expected %b",
                     {count, full, empty, valid_out, overflow, underflow, almost_full, almost_empty}, 11'b0000_0100000);
        else n_pass++;
        n_checks++;
        if (data_out !== 10'h000) $display("FAIL reset_data_out: got %h expected 000", data_out); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        cyc(S_RESET, 1'b0, 1'b0, 10'h000);
        umbral_superior = 4'd6;
        umbral_inferior = 4'd2;
        cyc(S_INIT, 1'b0, 1'b0, 10'h000);
        cyc(S_IDLE, 1'b0, 1'b0, 10'h000);
        n_checks++;
        if ({empty, count} !== 5'b1_0000) $display("FAIL init_empty_count: got %b expected 10000", {empty, count}); else n_pass++;
        n_checks++;
        if ({almost_empty, almost_full} !== 2'b10)
            $display("FAIL init_almost_flags: got %b expected 10", {almost_empty, almost_full});
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(S_ACTIVE, 1'b1, 1'b0, DW'(i));
            n_checks++;
            if ({count, almost_full, full} !== {4'(i), 1'(i >= 6), 1'(i == DEPTH)})
                $display("FAIL fill_%0d: got %b expected %b", i, {count, almost_full, full},
                         {4'(i), 1'(i >= 6), 1'(i == DEPTH)});
            else n_pass++;
        end
        cyc(S_ACTIVE, 1'b1, 1'b0, 10'h0AA);
        n_checks++;
        if ({overflow, count, full} !== 6'b1_1000_1)
            $display("FAIL overflow_push: got %b expected 110001", {overflow, count, full});
        else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(S_ACTIVE, 1'b0, 1'b1, 10'h000);
            n_checks++;
            if ({valid_out, data_out} !== {1'b1, DW'(i)})
                $display("FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, valid_out, data_out, DW'(i));
            else n_pass++;
        end
        n_checks++;
        if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty); else n_pass++;
        cyc(S_ACTIVE, 1'b0, 1'b1, 10'h000);
        n_checks++;
        if ({underflow, valid_out} !== 2'b10)
            $display("FAIL underflow_pop: got %b expected 10", {underflow, valid_out});
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp_seq [DEPTH];
        for (int k = 0; k < 3; k++) cyc(S_ACTIVE, 1'b1, 1'b0, DW'(10'h100 + k));
        for (int k = 0; k < 3; k++) cyc(S_ACTIVE, 1'b0, 1'b1, 10'h000);
        for (int i = 1; i <= DEPTH; i++) cyc(S_IDLE, 1'b1, 1'b0, DW'(i));
        cyc(S_ACTIVE, 1'b1, 1'b1, 10'h3FF);
        n_checks++;
        if ({valid_out, data_out, count, full} !== {1'b1, 10'h001, 4'd8, 1'b1})
            $display("FAIL full_push_pop: got v=%b d=%h c=%0d f=%b expected v=1 d=001 c=8 f=1",
                     valid_out, data_out, count, full);
        else n_pass++;
        for (int i = 0; i < DEPTH - 1; i++) exp_seq[i] = DW'(i + 2);
        exp_seq[DEPTH-1] = 10'h3FF;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(S_ACTIVE, 1'b0, 1'b1, 10'h000);
            n_checks++;
            if (data_out !== exp_seq[i])
                $display("FAIL wrap_drain_%0d: got %h expected %h", i, data_out, exp_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_zero();
        cyc(S_ACTIVE, 1'b1, 1'b0, 10'h000);
        cyc(S_ACTIVE, 1'b0, 1'b1, 10'h000);
        n_checks++;
        if ({valid_out, data_out} !== {1'b1, 10'h000})
            $display("FAIL zero_word: got valid=%b data=%h expected valid=1 data=000", valid_out, data_out);
        else n_pass++;
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_fwft();
        cyc(S_RESET, 1'b0, 1'b0, 10'h000);
        cyc(S_IDLE, 1'b1, 1'b0, 10'h155);
        n_checks++;
        if ({valid_out, data_out} !== {1'b1, 10'h155})
            $display("FAIL fwft_fall: got valid=%b data=%h expected valid=1 data=155", valid_out, data_out);
        else n_pass++;
        cyc(S_IDLE, 1'b0, 1'b1, 10'h000);
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL fwft_pop: got %b expected 0", valid_out); else n_pass++;
    endtask
`endif

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cyc(S_ACTIVE, 1'b1, 1'b0, DW'(10'h040 + i));
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({count, full, empty, valid_out, overflow, underflow, almost_full, almost_empty, data_out}
                !== {4'd0, 7'b0100000, 10'h000})
            $display("FAIL async_reset: got %b expected %b",
                     {count, full, empty, valid_out, overflow, underflow, almost_full, almost_empty, data_out},
                     {4'd0, 7'b0100000, 10'h000});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        cyc(S_IDLE, 1'b0, 1'b0, 10'h000);
        n_checks++;
        if ({almost_full, almost_empty, count} !== 6'b11_0000)
            $display("FAIL reset_thresholds: got %b expected 110000", {almost_full, almost_empty, count});
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]    st;
        logic          ps, pp;
        logic [DW-1:0] din;
        logic [10:0]   got_v, exp_v;
        bit            exp_af, exp_ae, exp_valid;
        int            r, p_push, p_pop;
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 99);
            st = (r < 2) ? S_RESET : (r < 6) ? S_INIT : (r < 50) ? S_IDLE : S_ACTIVE;
            if (st == S_INIT) begin
                umbral_superior = 4'($urandom_range(0, 15));
                umbral_inferior = 4'($urandom_range(0, 15));
            end
            p_push = ((i % 100) < 50) ? 75 : 30;
            p_pop  = ((i % 100) < 50) ? 30 : 75;
            ps  = ($urandom_range(0, 99) < p_push);
            pp  = ($urandom_range(0, 99) < p_pop);
            din = DW'($urandom);
            cyc(st, ps, pp, din);
            exp_af = !m_rst && (q.size() >= m_thr_hi);
            exp_ae = !m_rst && (q.size() <= m_thr_lo);
`ifdef FIFO_FWFT_EN
            exp_valid = (q.size() > 0);
`else
            exp_valid = m_valid;
`endif
            got_v = {count, full, empty, almost_full, almost_empty, overflow, underflow, valid_out};
            exp_v = {4'(q.size()), 1'(q.size() == DEPTH), 1'(q.size() == 0), exp_af, exp_ae, m_ovf, m_udf, exp_valid};
            n_checks++;
            if (got_v !== exp_v) $display("FAIL random_flags cycle %0d: got %b expected %b", i, got_v, exp_v);
            else n_pass++;
`ifdef FIFO_FWFT_EN
            if (q.size() > 0) begin
                n_checks++;
                if (data_out !== q[0]) $display("FAIL random_head cycle %0d: got %h expected %h", i, data_out, q[0]);
                else n_pass++;
            end
`else
            n_checks++;
            if (data_out !== m_dout) $display("FAIL random_data cycle %0d: got %h expected %h", i, data_out, m_dout);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
`ifdef FIFO_FWFT_EN
        test_fwft();
`else
        test_fill();
        test_drain();
        test_wrap();
        test_zero();
`endif
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parametrised successor to the transaction-layer 8x10 FIFO; buffers TLP words between the state machine and the downstream link logic.
- Generalises data width and depth, and adds a count output, full/empty/almost thresholds, sticky overflow/underflow errors, legal simultaneous push/pop, and an optional first-word-fall-through mode.
- Thresholds are latched under control of the transaction-layer state machine `state` input.

Parameters:
DATA_WIDTH, 10, width of each stored word
DEPTH, 8, number of entries; must be a power of 2 and at least 2
ADDR_WIDTH, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
state  in  4  state-machine state, one-hot: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000
push  in  1  write request
pop  in  1  read request
data_in  in  DATA_WIDTH  write data
umbral_superior  in  ADDR_WIDTH+1  almost-full threshold, latched in INIT
umbral_inferior  in  ADDR_WIDTH+1  almost-empty threshold, latched in INIT
data_out  out  DATA_WIDTH  read data
valid_out  out  1  data_out qualifier
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
full, empty  out  1 each  occupancy flags
almost_full, almost_empty  out  1 each  threshold flags
overflow, underflow  out  1 each  sticky error flags

Behaviour:
- Reset (async `reset`=1) and soft reset (`state`==RESET at a clock edge) have identical effect:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, valid_out=0, data_out=0.
  - overflow=0, underflow=0.
  - Both latched thresholds = 0.
  - almost_full=0 and almost_empty=0, forced low throughout reset/RESET.
- Asserting `reset` mid-transfer discards all contents; RAM contents are not cleared but are unreachable.
- Threshold latch: on each clock edge while `state`==INIT, thr_hi<=umbral_superior and thr_lo<=umbral_inferior. Values above DEPTH saturate to DEPTH. Thresholds hold in every other state.
- Acceptance rules:
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok). Push while full is accepted only together with an accepted pop.
- Push and pop are ignored in RESET and INIT. They operate in IDLE and ACTIVE.
- Zero data is stored like any other value; there is no data filtering.
- push_ok: RAM[wr_ptr]<=data_in; wr_ptr increments and wraps modulo DEPTH.
- pop_ok: rd_ptr increments and wraps modulo DEPTH.
- count update: +1 on push_ok only, -1 on pop_ok only, unchanged when both occur.
- Flags are registered and consistent with count in the same cycle:
  - full = (count==DEPTH); empty = (count==0).
  - almost_full = (count>=thr_hi); almost_empty = (count<=thr_lo).
- Error flags:
  - overflow sets when push & !push_ok.
  - underflow sets when pop & empty.
  - Both stay set until reset or RESET.
- Standard read mode: on pop_ok, data_out<=RAM[rd_ptr] and valid_out=1 on the following cycle (1-cycle latency). valid_out drops the cycle after a non-accepted pop. data_out holds its last value otherwise.
- Read-during-write to the same address (full with simultaneous push/pop) returns the old data.

Optional Feature:
- FIFO_FWFT_EN defined: first-word-fall-through.
  - data_out always presents the head entry and valid_out = !empty.
  - A word pushed into an empty FIFO appears on data_out 1 cycle after the push edge.
  - pop_ok advances to the next entry on the next cycle with no bubble.
  - Underflow rules are unchanged.
- FIFO_FWFT_EN undefined: standard 1-cycle registered read described above.

Decomposition:
- Package fifo_pkg holds:
  - State encodings: ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE (4-bit one-hot).
  - A function clog2 for pointer-width derivation.
- Sub-module fifo_dpram (params DATA_WIDTH, DEPTH):
  - Simple dual-port RAM with one write port and one registered read port.
  - Read-before-write on same-address collision; no reset on the storage array.
  - The FIFO core keeps pointers, count, flags and FWFT prefetch.

Test Plan (DATA_WIDTH=10, DEPTH=8, standard mode unless noted):
- Reset, then INIT with umbral_superior=6, umbral_inferior=2, then IDLE -> empty=1, count=0; almost_empty=1 after leaving RESET; almost_full=0.
- Push 0x001..0x008 -> count=8, full=1; almost_full from count=6; 9th push -> overflow=1, count stays 8, contents unchanged.
- Pop 8 times -> data_out 0x001..0x008 each 1 cycle after its pop; empty=1; an extra pop -> underflow=1, valid_out=0.
- Full FIFO, push 0x3FF with pop on the same cycle -> popped 0x001, count stays 8; 0x3FF is read after 0x008; pointers wrap cleanly.
- Push 0x000 -> stored and read back as 0x000 with valid_out=1.
- Assert reset after 5 pushes mid-burst -> all outputs at reset values immediately (async); thresholds 0.
- FIFO_FWFT_EN: push 0x155 into empty FIFO -> data_out=0x155, valid_out=1 next cycle without a pop; pop -> valid_out=0.
